freq_divider: RTL and testbench

FREQ_DIVIDER -- requirements
Module: freq_divider

---
 rtl/freq_div_pkg.sv | 12 +
 rtl/freq_divider_tog_stage.sv | 42 ++++
 rtl/freq_divider.sv | 141 ++++++++++++++
 tb/tb_freq_divider.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared definitions for the frequency divider: FSM state encoding and default width.
package freq_div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage : freq_div_pkg

// File: rtl/freq_divider_tog_stage.sv
// T flip-flop stage: toggles q_div on every tick and keeps qb_div as its registered complement.
module tog_stage (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic q_div,
    output logic qb_div
);

    logic q_d;
    logic qb_d;
    logic q_q;
    logic qb_q;

    // Next-state toggle; qb is held in its own flop so both outputs change on the same edge.
    always_comb begin
        q_d  = q_q;
        qb_d = qb_q;
        if (tick) begin
            q_d  = ~q_q;
            qb_d = q_q;
        end else begin
            q_d  = q_q;
            qb_d = ~q_q;
        end
    end

    // Toggle register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q  <= 1'b0;
            qb_q <= 1'b1;
        end else begin
            q_q  <= q_d;
            qb_q <= qb_d;
        end
    end

    assign q_div  = q_q;
    assign qb_div = qb_q;

endmodule : tog_stage

// File: rtl/freq_divider.sv
// Programmable clock-enable divider: emits a tick every N enabled cycles and drives a
// toggle stage that produces a 50% duty clk/(2N) data output.
module freq_divider
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_n,
    output logic             tick,
    output logic             q_div,
    output logic             qb_div,
    output logic             running,
    output logic             err
);

    state_e           state_d;
    state_e           state_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] div_d;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] shadow_q;
    logic             tick_d;
    logic             tick_q;
    logic             running_d;
    logic             running_q;
    logic             err_d;
    logic             err_q;
    logic             load_zero_s;
    logic             wrap_s;

    assign load_zero_s = load && (div_n == {WIDTH{1'b0}});
    assign wrap_s      = (count_q == (div_q - WIDTH'(1'b1)));

    // Next-state logic. A zero shadow value means no pending divisor, since N=0 is never accepted.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        tick_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (load_zero_s) begin
                    err_d = 1'b1;
                end else if (load) begin
                    state_d  = RUN;
                    div_d    = div_n;
                    count_d  = {WIDTH{1'b0}};
                    shadow_d = {WIDTH{1'b0}};
                    err_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN, HOLD: begin
                if (load_zero_s) begin
                    state_d  = IDLE;
                    count_d  = {WIDTH{1'b0}};
                    div_d    = {WIDTH{1'b0}};
                    shadow_d = {WIDTH{1'b0}};
                    err_d    = 1'b1;
                end else begin
                    state_d = en ? RUN : HOLD;
                    if (load) begin
                        shadow_d = div_n;
                        err_d    = 1'b0;
                    end else begin
                        shadow_d = shadow_q;
                    end
                    if (en && wrap_s) begin
                        // A load coinciding with the wrap takes effect for the very next period.
                        count_d = {WIDTH{1'b0}};
                        tick_d  = 1'b1;
                        if (load) begin
                            div_d    = div_n;
                            shadow_d = {WIDTH{1'b0}};
                        end else if (shadow_q != {WIDTH{1'b0}}) begin
                            div_d    = shadow_q;
                            shadow_d = {WIDTH{1'b0}};
                        end else begin
                            div_d = div_q;
                        end
                    end else if (en) begin
                        count_d = count_q + WIDTH'(1'b1);
                    end else begin
                        count_d = count_q;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                count_d  = {WIDTH{1'b0}};
                div_d    = {WIDTH{1'b0}};
                shadow_d = {WIDTH{1'b0}};
                err_d    = err_q;
            end
        endcase
        running_d = (state_d == RUN);
    end

    // Divider FSM, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= {WIDTH{1'b0}};
            div_q     <= {WIDTH{1'b0}};
            shadow_q  <= {WIDTH{1'b0}};
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            err_q     <= err_d;
        end
    end

    tog_stage u_tog_stage (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick_q),
        .q_div  (q_div),
        .qb_div (qb_div)
    );

    assign tick    = tick_q;
    assign running = running_q;
    assign err     = err_q;

endmodule : freq_divider

// File: tb/tb_freq_divider.sv
// Directed self-checking bench for freq_divider; expected tick pattern is hand-derived per step.
module tb_freq_divider;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] div_n = 8'd0;
    logic       tick;
    logic       q_div;
    logic       qb_div;
    logic       running;
    logic       err;

    int   n_checks = 0;
    int   n_err = 0;
    logic exp_q = 1'b0;
    logic prev_tick = 1'b0;

    freq_divider #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .div_n   (div_n),
        .tick    (tick),
        .q_div   (q_div),
        .qb_div  (qb_div),
        .running (running),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // One clock edge; q toggles on an edge where tick was high beforehand.
    task automatic edge_step(input logic et, input string tag);
        logic exp_qb;
        @(posedge clk);
        #1;
        if (prev_tick) exp_q = ~exp_q;
        prev_tick = et;
        exp_qb = ~exp_q;
        chk({tag, " tick"}, tick, et);
        chk({tag, " q_div"}, q_div, exp_q);
        chk({tag, " qb_div"}, qb_div, exp_qb);
    endtask

    task automatic do_reset(input string tag);
        load  = 1'b0;
        reset = 1'b0;
        #2;
        exp_q = 1'b0;
        prev_tick = 1'b0;
        chk({tag, " rst tick"}, tick, 1'b0);
        chk({tag, " rst q_div"}, q_div, 1'b0);
        chk({tag, " rst qb_div"}, qb_div, 1'b1);
        chk({tag, " rst running"}, running, 1'b0);
        chk({tag, " rst err"}, err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        do_reset("init");
        edge_step(1'b0, "idle");
        chk("idle running", running, 1'b0);

        // N=4: ticks 4,8,12,16,20 edges after the load
        load = 1'b1; div_n = 8'd4; en = 1'b1;
        edge_step(1'b0, "t32 load");
        chk("t32 running", running, 1'b1);
        load = 1'b0;
        for (int k = 1; k <= 20; k++) edge_step((k % 4) == 0, "t32");

        // N=3 with a five-cycle hold at count=1
        do_reset("t33");
        load = 1'b1; div_n = 8'd3; en = 1'b1;
        edge_step(1'b0, "t33 load");
        load = 1'b0;
        edge_step(1'b0, "t33 c1");
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            edge_step(1'b0, "t33 hold");
            chk("t33 hold running", running, 1'b0);
        end
        en = 1'b1;
        edge_step(1'b0, "t33 resume1");
        chk("t33 resume running", running, 1'b1);
        edge_step(1'b1, "t33 resume2");
        edge_step(1'b0, "t33 r3");
        edge_step(1'b0, "t33 r4");
        edge_step(1'b1, "t33 r5");

        // N=5, reload 2 mid-period, then reload 3 on the wrap edge
        do_reset("t34");
        load = 1'b1; div_n = 8'd5; en = 1'b1;
        edge_step(1'b0, "t34 load");
        load = 1'b0;
        edge_step(1'b0, "t34 e1");
        edge_step(1'b0, "t34 e2");
        load = 1'b1; div_n = 8'd2;
        edge_step(1'b0, "t34 e3");
        load = 1'b0;
        edge_step(1'b0, "t34 e4");
        edge_step(1'b1, "t34 oldwrap");
        edge_step(1'b0, "t34 e6");
        edge_step(1'b1, "t34 e7");
        edge_step(1'b0, "t34 e8");
        edge_step(1'b1, "t34 e9");
        edge_step(1'b0, "t34 e10");
        edge_step(1'b1, "t34 e11");
        edge_step(1'b0, "t34 e12");
        load = 1'b1; div_n = 8'd3;
        edge_step(1'b1, "t34 loadwrap");
        load = 1'b0;
        edge_step(1'b0, "t34 e14");
        edge_step(1'b0, "t34 e15");
        edge_step(1'b1, "t34 e16");

        // Load 0 while running, then recover with N=1
        load = 1'b1; div_n = 8'd0;
        edge_step(1'b0, "t35 zero");
        chk("t35 err set", err, 1'b1);
        chk("t35 idle running", running, 1'b0);
        load = 1'b0;
        edge_step(1'b0, "t35 idle");
        chk("t35 err sticky", err, 1'b1);
        load = 1'b1; div_n = 8'd1;
        edge_step(1'b0, "t35 load1");
        chk("t35 err clear", err, 1'b0);
        chk("t35 running", running, 1'b1);
        load = 1'b0;
        for (int k = 0; k < 4; k++) edge_step(1'b1, "t35 n1");

        // N=6, reset at count=5 with q_div high
        do_reset("t36pre");
        load = 1'b1; div_n = 8'd6; en = 1'b1;
        edge_step(1'b0, "t36 load");
        load = 1'b0;
        for (int k = 1; k <= 5; k++) edge_step(1'b0, "t36 a");
        edge_step(1'b1, "t36 tick");
        for (int k = 7; k <= 11; k++) edge_step(1'b0, "t36 b");
        chk("t36 q high before reset", q_div, 1'b1);
        do_reset("t36");
        for (int k = 0; k < 8; k++) begin
            edge_step(1'b0, "t36 quiet");
            chk("t36 quiet running", running, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_freq_divider
